cnt_seq_ctrl: RTL and testbench

- Command-driven sequencer for a my_74193-style nibble counter (load_en/din/inc_en/dec_en in, dout out; 1-cycle update latency).
- Accepts LOAD / UP-by-N / DOWN-by-N commands over a valid/ready handshake.
- Drives the counter strobes for exactly the required cycles, then reports the settled count and a wrap flag.
- Sits between a host/test controller and one counter instance in core-level logic.

---
 rtl/cnt_seq_pkg.sv | 27 ++
 rtl/cnt_seq_ctrl_rst_ena_dly.sv | 38 +++
 rtl/cnt_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_cnt_seq_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_seq_pkg.sv
// ----------------------------------------------------------------------------
// cnt_seq_pkg
//   Shared definitions for the counter command sequencer:
//     - command op encodings carried on cmd_op
//     - FSM state encoding, also visible on the dbg_state port
//     - default counter width
// ----------------------------------------------------------------------------
package cnt_seq_pkg;

    // Default width of the controlled counter (a 74193-style nibble counter).
    localparam int CNT_W_DEF = 4;

    // Command op encodings.
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    // FSM state encoding.
    localparam int         ST_W      = 3;
    localparam logic [2:0] ST_WARMUP = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

endpackage : cnt_seq_pkg

// File: rtl/cnt_seq_ctrl_rst_ena_dly.sv
// ----------------------------------------------------------------------------
// rst_ena_dly
//   Post-reset enable delay. A DEPTH-deep shift register that is cleared by
//   the asynchronous reset and shifts in a 1 every clock afterwards. ena_o
//   rises DEPTH clocks after reset release and stays high until the next
//   reset.
//
//   Ports:
//     clk_i  in   clock, rising edge
//     rst_ni in   asynchronous active-low reset
//     ena_o  out  high once DEPTH clocks have elapsed since reset release
// ----------------------------------------------------------------------------
module rst_ena_dly #(
    parameter int DEPTH = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic ena_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift toward the MSB with a constant 1 entering at bit 0; written as a
    // shift-or so that DEPTH=1 needs no special case.
    assign sr_d = (sr_q << 1) | DEPTH'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign ena_o = sr_q[DEPTH-1];

endmodule : rst_ena_dly

// File: rtl/cnt_seq_ctrl.sv
// ----------------------------------------------------------------------------
// cnt_seq_ctrl
//   Command-driven sequencer for one 74193-style counter (load/inc/dec
//   strobes in, count out, one-cycle update latency). A host issues LOAD,
//   UP-by-N or DOWN-by-N commands; the controller drives the counter strobes
//   for exactly the required number of cycles, waits one settle cycle, then
//   reports the final count, a wrap flag and an abort flag with a one-cycle
//   done pulse.
//
//   Command handshake: a command transfers on a rising clock edge where
//   cmd_valid and cmd_ready are both high. cmd_ready is high only in IDLE.
//   A host that raises cmd_valid while cmd_ready is low must hold cmd_op and
//   cmd_arg stable until the transfer edge; nothing is queued.
//
//   Ports:
//     clk, reset_n        clock (rising edge), async active-low reset
//     cmd_valid/ready     command handshake
//     cmd_op, cmd_arg     op (LOAD/UP/DOWN/NOP) and load value / step count
//     abort               ends an UP/DOWN after the current strobe
//     load_en, din        counter parallel-load strobe and data
//     inc_en, dec_en      counter count strobes
//     cnt_in              counter output
//     busy                command in progress
//     done                one-cycle completion pulse
//     done_cnt            counter value at completion (held)
//     done_wrap           completed UP/DOWN crossed the counter range (held)
//     done_abort          completed command was aborted (held)
//     dbg_state           current FSM state
//
//   All outputs are registered. Timing from the accept edge A (cycle A+n is
//   the cycle following the n-th edge after A's cycle begins):
//     LOAD          : load_en in A+1, SETTLE A+2, done A+3
//     UP/DOWN N>=1  : strobes A+1..A+N, SETTLE A+N+1, done A+N+2
//     UP/DOWN N=0   : SETTLE A+1, done A+2
// ----------------------------------------------------------------------------
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int ENA_DLY = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             abort,
    output logic             load_en,
    output logic [CNT_W-1:0] din,
    output logic             inc_en,
    output logic             dec_en,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] done_cnt,
    output logic             done_wrap,
    output logic             done_abort,
    output logic [ST_W-1:0]  dbg_state
);

    // ------------------------------------------------------------------
    // Warm-up enable
    // ------------------------------------------------------------------
    logic ena;

    rst_ena_dly #(
        .DEPTH (ENA_DLY)
    ) u_rst_ena_dly (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .ena_o  (ena)
    );

    // ------------------------------------------------------------------
    // State and command context
    // ------------------------------------------------------------------
    logic [ST_W-1:0]  state_q,   state_d;
    logic [1:0]       op_q,      op_d;
    logic [CNT_W-1:0] arg_q,     arg_d;
    logic [CNT_W-1:0] start_q,   start_d;
    // Number of strobes issued so far for the current UP/DOWN.
    logic [CNT_W-1:0] steps_q,   steps_d;
    logic             abort_q,   abort_d;

    // Registered outputs
    logic             cmd_ready_q,  cmd_ready_d;
    logic             load_en_q,    load_en_d;
    logic [CNT_W-1:0] din_q,        din_d;
    logic             inc_en_q,     inc_en_d;
    logic             dec_en_q,     dec_en_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;
    logic [CNT_W-1:0] done_cnt_q,   done_cnt_d;
    logic             done_wrap_q,  done_wrap_d;
    logic             done_abort_q, done_abort_d;

    logic             accept;
    logic [CNT_W-1:0] issued;
    logic [CNT_W:0]   up_sum;
    logic             wrap_up;
    logic             wrap_dn;

    assign accept = cmd_valid & cmd_ready_q;

    // Strobe count including the one ending at this edge.
    assign issued = steps_q + CNT_W'(1);

    // Wrap is judged from the start value and the strobes actually issued,
    // so an aborted run reports only what really happened to the counter.
    // UP wraps when the CNT_W+1-bit sum carries out; DOWN wraps when more
    // decrements were issued than the start value.
    assign up_sum  = {1'b0, start_q} + {1'b0, steps_q};
    assign wrap_up = up_sum[CNT_W];
    assign wrap_dn = (steps_q > start_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        arg_d        = arg_q;
        start_d      = start_q;
        steps_d      = steps_q;
        abort_d      = abort_q;
        load_en_d    = 1'b0;
        din_d        = din_q;
        inc_en_d     = 1'b0;
        dec_en_d     = 1'b0;
        done_d       = 1'b0;
        done_cnt_d   = done_cnt_q;
        done_wrap_d  = done_wrap_q;
        done_abort_d = done_abort_q;

        case (state_q)
            ST_WARMUP: begin
                if (ena) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (accept) begin
                    op_d    = cmd_op;
                    arg_d   = cmd_arg;
                    start_d = cnt_in;
                    steps_d = '0;
                    abort_d = 1'b0;
                    case (cmd_op)
                        OP_LOAD: begin
                            state_d   = ST_LOAD;
                            load_en_d = 1'b1;
                            din_d     = cmd_arg;
                        end
                        OP_UP, OP_DOWN: begin
                            if (cmd_arg == '0) begin
                                // Zero-step move: nothing to strobe.
                                state_d = ST_SETTLE;
                            end else begin
                                state_d  = ST_RUN;
                                inc_en_d = (cmd_op == OP_UP);
                                dec_en_d = (cmd_op == OP_DOWN);
                            end
                        end
                        OP_NOP: begin
                            state_d = ST_IDLE;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_LOAD: begin
                state_d = ST_SETTLE;
            end

            ST_RUN: begin
                // The step counter alone decides termination; cnt_in is
                // never consulted, so a wrapping counter cannot stall us.
                steps_d = issued;
                if ((issued == arg_q) || abort) begin
                    state_d = ST_SETTLE;
                    abort_d = abort;
                end else begin
                    inc_en_d = (op_q == OP_UP);
                    dec_en_d = (op_q == OP_DOWN);
                end
            end

            ST_SETTLE: begin
                // The last strobe has been absorbed by the counter, so
                // cnt_in is final here.
                state_d      = ST_IDLE;
                done_d       = 1'b1;
                done_cnt_d   = cnt_in;
                done_abort_d = abort_q;
                case (op_q)
                    OP_UP:   done_wrap_d = wrap_up;
                    OP_DOWN: done_wrap_d = wrap_dn;
                    default: done_wrap_d = 1'b0;
                endcase
            end

            default: begin
                state_d = ST_WARMUP;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_RUN) ||
                      (state_d == ST_SETTLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_WARMUP;
            op_q         <= OP_NOP;
            arg_q        <= '0;
            start_q      <= '0;
            steps_q      <= '0;
            abort_q      <= 1'b0;
            cmd_ready_q  <= 1'b0;
            load_en_q    <= 1'b0;
            din_q        <= '0;
            inc_en_q     <= 1'b0;
            dec_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_cnt_q   <= '0;
            done_wrap_q  <= 1'b0;
            done_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            arg_q        <= arg_d;
            start_q      <= start_d;
            steps_q      <= steps_d;
            abort_q      <= abort_d;
            cmd_ready_q  <= cmd_ready_d;
            load_en_q    <= load_en_d;
            din_q        <= din_d;
            inc_en_q     <= inc_en_d;
            dec_en_q     <= dec_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            done_cnt_q   <= done_cnt_d;
            done_wrap_q  <= done_wrap_d;
            done_abort_q <= done_abort_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready  = cmd_ready_q;
    assign load_en    = load_en_q;
    assign din        = din_q;
    assign inc_en     = inc_en_q;
    assign dec_en     = dec_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_cnt   = done_cnt_q;
    assign done_wrap  = done_wrap_q;
    assign done_abort = done_abort_q;
    assign dbg_state  = state_q;

endmodule : cnt_seq_ctrl

// File: tb/tb_cnt_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cnt_seq_ctrl
//   Bench for cnt_seq_ctrl. A behavioural nibble counter closes the loop;
//   expected results come from arithmetic on start value, op, step count and
//   abort point.
// ----------------------------------------------------------------------------
module tb_cnt_seq_ctrl;

    localparam int W   = 4;
    localparam int DLY = 3;
    localparam int MOD = 1 << W;

    localparam logic [1:0] T_LOAD = 2'b00;
    localparam logic [1:0] T_UP   = 2'b01;
    localparam logic [1:0] T_DOWN = 2'b10;
    localparam logic [1:0] T_NOP  = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_arg;
    logic          abort;
    logic          load_en;
    logic [W-1:0]  din;
    logic          inc_en;
    logic          dec_en;
    logic [W-1:0]  cnt_m;
    logic          busy;
    logic          done;
    logic [W-1:0]  done_cnt;
    logic          done_wrap;
    logic          done_abort;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    int last_wait;
    logic [W-1:0] last_done;
    logic [W-1:0] exp_q[$];

    cnt_seq_ctrl #(
        .CNT_W   (W),
        .ENA_DLY (DLY)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .abort      (abort),
        .load_en    (load_en),
        .din        (din),
        .inc_en     (inc_en),
        .dec_en     (dec_en),
        .cnt_in     (cnt_m),
        .busy       (busy),
        .done       (done),
        .done_cnt   (done_cnt),
        .done_wrap  (done_wrap),
        .done_abort (done_abort),
        .dbg_state  (dbg_state)
    );

    // Behavioural 74193-style counter: one-cycle update, wraps modulo 2^W.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)      cnt_m <= '0;
        else if (load_en)  cnt_m <= din;
        else if (inc_en)   cnt_m <= cnt_m + 4'd1;
        else if (dec_en)   cnt_m <= cnt_m - 4'd1;
    end

    // Strobes must never overlap.
    always @(negedge clk) begin
        if (reset_n) begin
            total++;
            if ((int'(load_en) + int'(inc_en) + int'(dec_en)) > 1) begin
                bad++;
                $display("FAIL strobe_excl load=%0b inc=%0b dec=%0b (at most one high)",
                         load_en, inc_en, dec_en);
            end
        end
    end

    // ---------------- driver + checker for one command ----------------
    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] arg,
                           input int abort_at, input bit hold_valid, input string tag);
        int start_v, k, exp_cnt, exp_lat, exp_inc, exp_dec, exp_load, exp_last;
        int n_inc, n_dec, n_load, n_busy, last_st, j, wait_n;
        bit exp_wrap, exp_ab, seen;
        logic [W-1:0] exp_c;
        n_inc = 0; n_dec = 0; n_load = 0; n_busy = 0; last_st = 0;
        cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
        wait_n = 0;
        while (cmd_ready !== 1'b1 && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        last_wait = wait_n;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_timeout ready=%b want 1", tag, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        // Reference model
        start_v  = int'(cnt_m);
        k        = 0;
        exp_ab   = 1'b0;
        exp_wrap = 1'b0;
        if (op == T_UP || op == T_DOWN) begin
            k = (abort_at > 0) ? abort_at : int'(arg);
            exp_ab = (abort_at > 0);
        end
        if (op == T_LOAD) begin
            exp_cnt = int'(arg);
            exp_lat = 3;
        end else if (op == T_UP) begin
            exp_cnt  = (start_v + k) % MOD;
            exp_wrap = (start_v + k) > (MOD - 1);
            exp_lat  = (arg == 0) ? 2 : k + 2;
        end else begin
            exp_cnt  = (start_v - k + MOD) % MOD;
            exp_wrap = (k > start_v);
            exp_lat  = (arg == 0) ? 2 : k + 2;
        end
        exp_inc  = (op == T_UP)   ? k : 0;
        exp_dec  = (op == T_DOWN) ? k : 0;
        exp_load = (op == T_LOAD) ? 1 : 0;
        exp_last = (op == T_LOAD) ? 1 : k;
        exp_q.push_back(W'(exp_cnt));

        @(posedge clk); #1;            // accept edge; now in cycle A+1
        if (!hold_valid) cmd_valid = 1'b0;
        seen = 1'b0;
        j = 0;
        while (!seen && j < 60) begin
            if (inc_en === 1'b1) begin n_inc++; last_st = j + 1; end
            if (dec_en === 1'b1) begin n_dec++; last_st = j + 1; end
            if (load_en === 1'b1) begin
                n_load++; last_st = j + 1;
                total++;
                if (din !== arg) begin
                    bad++;
                    $display("FAIL %s din got=%0d want=%0d", tag, din, arg);
                end
            end
            if (busy === 1'b1) n_busy++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                abort = (abort_at > 0 && j + 1 == abort_at);
                @(posedge clk); #1;
                j++;
            end
        end
        abort = 1'b0;
        cmd_valid = 1'b0;
        exp_c = exp_q.pop_front();
        last_done = exp_c;

        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s done_timeout no done within 60 cycles", tag);
            return;
        end
        total++;
        if (j + 1 != exp_lat) begin
            bad++;
            $display("FAIL %s latency got=A+%0d want=A+%0d", tag, j + 1, exp_lat);
        end
        total++;
        if (done_cnt !== exp_c) begin
            bad++;
            $display("FAIL %s done_cnt got=%0d want=%0d", tag, done_cnt, exp_c);
        end
        total++;
        if (done_wrap !== exp_wrap) begin
            bad++;
            $display("FAIL %s done_wrap got=%b want=%b", tag, done_wrap, exp_wrap);
        end
        total++;
        if (done_abort !== exp_ab) begin
            bad++;
            $display("FAIL %s done_abort got=%b want=%b", tag, done_abort, exp_ab);
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_at_done got=%b want=1", tag, cmd_ready);
        end
        total++;
        if (n_inc != exp_inc || n_dec != exp_dec || n_load != exp_load || last_st != exp_last) begin
            bad++;
            $display("FAIL %s strobes got inc=%0d dec=%0d load=%0d last=%0d want inc=%0d dec=%0d load=%0d last=%0d",
                     tag, n_inc, n_dec, n_load, last_st, exp_inc, exp_dec, exp_load, exp_last);
        end
        total++;
        if (n_busy != exp_lat - 1) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d want=%0d", tag, n_busy, exp_lat - 1);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        total++;
        if (load_en !== 1'b0 || inc_en !== 1'b0 || dec_en !== 1'b0 || din !== '0) begin
            bad++;
            $display("FAIL reset_strobes load=%b inc=%b dec=%b din=%0d want all 0",
                     load_en, inc_en, dec_en, din);
        end
        total++;
        if (done !== 1'b0 || done_cnt !== '0 || done_wrap !== 1'b0 || done_abort !== 1'b0) begin
            bad++;
            $display("FAIL reset_done done=%b cnt=%0d wrap=%b abort=%b want all 0",
                     done, done_cnt, done_wrap, done_abort);
        end
        total++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs ready=%b busy=%b want 0 0", cmd_ready, busy);
        end
    endtask

    // Releases reset and checks cmd_ready stays low through the warm-up.
    task automatic release_and_warmup(input string tag);
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= DLY + 1; e++) begin
            @(posedge clk); #1;
            total++;
            if (cmd_ready !== (e > DLY) || done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL %s edge%0d ready=%b done=%b busy=%b want ready=%b done=0 busy=0",
                         tag, e, cmd_ready, done, busy, (e > DLY));
            end
        end
    endtask

    task automatic test_warmup();
        cmd_valid = 1'b1; cmd_op = T_UP; cmd_arg = 4'd2;
        release_and_warmup("warmup");
        run_cmd(T_UP, 4'd2, 0, 1'b0, "warmup_up2");
        total++;
        if (last_wait != 0) begin
            bad++;
            $display("FAIL warmup_accept wait=%0d want 0", last_wait);
        end
    endtask

    task automatic test_down();
        run_cmd(T_DOWN, 4'd4, 0, 1'b0, "down4_wrap");
        run_cmd(T_DOWN, 4'd0, 0, 1'b0, "down0");
    endtask

    task automatic test_load();
        run_cmd(T_LOAD, 4'd0, 0, 1'b0, "load0");
        run_cmd(T_LOAD, 4'd9, 0, 1'b0, "load9");
    endtask

    task automatic test_up();
        run_cmd(T_UP, 4'd5, 0, 1'b0, "up5");
        run_cmd(T_UP, 4'd3, 0, 1'b0, "up3_wrap");
        run_cmd(T_UP, 4'd15, 0, 1'b0, "up15_max");
    endtask

    task automatic test_abort();
        run_cmd(T_LOAD, 4'd0, 0, 1'b0, "abort_pre_load");
        run_cmd(T_UP, 4'd10, 3, 1'b0, "up10_abort3");
        run_cmd(T_DOWN, 4'd9, 5, 1'b0, "down9_abort5_wrap");
        // abort is ignored outside RUN
        abort = 1'b1;
        run_cmd(T_LOAD, 4'd6, 0, 1'b0, "load_abort_ignored");
        abort = 1'b0;
    endtask

    task automatic test_nop();
        int bad_cyc;
        cmd_op = T_NOP; cmd_arg = 4'd7; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        bad_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
                load_en !== 1'b0 || inc_en !== 1'b0 || dec_en !== 1'b0) bad_cyc++;
            @(posedge clk); #1;
        end
        total++;
        if (bad_cyc != 0) begin
            bad++;
            $display("FAIL nop_quiet cycles_with_activity=%0d want 0", bad_cyc);
        end
        total++;
        if (done_cnt !== last_done) begin
            bad++;
            $display("FAIL nop_hold done_cnt got=%0d want=%0d", done_cnt, last_done);
        end
    endtask

    task automatic test_hold_valid();
        run_cmd(T_UP, 4'd4, 0, 1'b1, "hold_valid_up4");
        run_cmd(T_LOAD, 4'd12, 0, 1'b1, "hold_valid_load12");
    endtask

    task automatic test_back_to_back();
        run_cmd(T_UP, 4'd2, 0, 1'b0, "b2b_0");
        run_cmd(T_DOWN, 4'd1, 0, 1'b0, "b2b_1");
        total++;
        if (last_wait != 0) begin
            bad++;
            $display("FAIL b2b_accept1 wait=%0d want 0", last_wait);
        end
        run_cmd(T_UP, 4'd0, 0, 1'b0, "b2b_2");
        total++;
        if (last_wait != 0) begin
            bad++;
            $display("FAIL b2b_accept2 wait=%0d want 0", last_wait);
        end
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] arg;
        int ab;
        bit hv;
        for (int i = 0; i < 24; i++) begin
            op  = 2'($urandom_range(0, 2));
            arg = W'($urandom_range(0, MOD - 1));
            hv  = 1'($urandom_range(0, 1));
            ab  = 0;
            if ((op == T_UP || op == T_DOWN) && arg >= 2 && $urandom_range(0, 2) == 0)
                ab = $urandom_range(1, int'(arg) - 1);
            run_cmd(op, arg, ab, hv, $sformatf("rand%0d", i));
            if ($urandom_range(0, 5) == 0) test_nop();
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        cmd_op = T_UP; cmd_arg = 4'd8; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (inc_en === 1'b1) n++;
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL midrun_strobes got=%0d want 4", n);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (inc_en !== 1'b0 || dec_en !== 1'b0 || load_en !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || cmd_ready !== 1'b0 || done_cnt !== '0 || din !== '0) begin
            bad++;
            $display("FAIL midrun_reset inc=%b dec=%b load=%b busy=%b done=%b ready=%b cnt=%0d din=%0d want all 0",
                     inc_en, dec_en, load_en, busy, done, cmd_ready, done_cnt, din);
        end
        repeat (2) @(posedge clk);
        release_and_warmup("rewarm");
        run_cmd(T_LOAD, 4'd5, 0, 1'b0, "post_reset_load5");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = T_NOP;
        cmd_arg   = '0;
        abort     = 1'b0;
        last_done = '0;
        last_wait = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_warmup();
        test_down();
        test_load();
        test_up();
        test_abort();
        test_nop();
        test_hold_valid();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_cnt_seq_ctrl
